// File: rtl/rd_req_arbiter.sv
// Two-requester round-robin arbiter for the shared cache-line read-request port.
// Requests are tagged with the requester ID, responses are routed back by that tag.
module rd_req_arbiter #(
    parameter int ADDR_LMT        = 20,
    parameter int MDATA           = 14,
    parameter int CACHE_WIDTH     = 512,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_LMT-1:0]    req0_addr,
    input  logic [MDATA-2:0]       req0_mdata,
    input  logic                   req0_en,
    output logic                   req0_grant,
    output logic                   req0_almostfull,
    input  logic [ADDR_LMT-1:0]    req1_addr,
    input  logic [MDATA-2:0]       req1_mdata,
    input  logic                   req1_en,
    output logic                   req1_grant,
    output logic                   req1_almostfull,
    output logic [ADDR_LMT-1:0]    rd_req_addr,
    output logic [MDATA-1:0]       rd_req_mdata,
    output logic                   rd_req_en,
    input  logic                   rd_req_almostfull,
    input  logic                   rd_rsp_valid,
    input  logic [MDATA-1:0]       rd_rsp_mdata,
    input  logic [CACHE_WIDTH-1:0] rd_rsp_data,
    output logic                   rsp0_valid,
    output logic [MDATA-2:0]       rsp0_mdata,
    output logic [CACHE_WIDTH-1:0] rsp0_data,
    output logic                   rsp1_valid,
    output logic [MDATA-2:0]       rsp1_mdata,
    output logic [CACHE_WIDTH-1:0] rsp1_data,
    output logic                   idle,
    output logic                   err
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CNT_HI   = CW'(MAX_OUTSTANDING - 1);

    logic [CW-1:0]          cnt0_r, cnt1_r;
    logic                   last_r;
    logic                   err_r;
    logic                   rd_req_en_r;
    logic [ADDR_LMT-1:0]    rd_req_addr_r;
    logic [MDATA-1:0]       rd_req_mdata_r;
    logic                   rsp0_valid_r, rsp1_valid_r;
    logic [MDATA-2:0]       rsp_mdata_r;
    logic [CACHE_WIDTH-1:0] rsp_data_r;

    logic elig0_s, elig1_s, grant0_s, grant1_s;
    logic rsp_id_s, dec0_s, dec1_s;

    // Saturating-at-zero credit counter step; simultaneous inc and dec cancel.
    function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] cnt,
                                               input logic inc, input logic dec);
        logic [CW-1:0] res;
        case ({inc, dec})
            2'b10:   res = cnt + CNT_ONE;
            2'b01:   res = (cnt == CNT_ZERO) ? cnt : cnt - CNT_ONE;
            default: res = cnt;
        endcase
        return res;
    endfunction

    assign elig0_s  = reset_n & req0_en & ~rd_req_almostfull & (cnt0_r != CNT_MAX);
    assign elig1_s  = reset_n & req1_en & ~rd_req_almostfull & (cnt1_r != CNT_MAX);
    assign rsp_id_s = rd_rsp_mdata[MDATA-1];
    assign dec0_s   = rd_rsp_valid & ~rsp_id_s;
    assign dec1_s   = rd_rsp_valid &  rsp_id_s;

    // Round-robin grant: on a tie the requester that did not win last time goes.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (elig0_s && elig1_s) begin
            if (last_r) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (elig0_s) begin
            grant0_s = 1'b1;
        end else if (elig1_s) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Shared request output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_req_en_r    <= 1'b0;
            rd_req_addr_r  <= {ADDR_LMT{1'b0}};
            rd_req_mdata_r <= {MDATA{1'b0}};
            last_r         <= 1'b1;
        end else if (grant0_s) begin
            rd_req_en_r    <= 1'b1;
            rd_req_addr_r  <= req0_addr;
            rd_req_mdata_r <= {1'b0, req0_mdata};
            last_r         <= 1'b0;
        end else if (grant1_s) begin
            rd_req_en_r    <= 1'b1;
            rd_req_addr_r  <= req1_addr;
            rd_req_mdata_r <= {1'b1, req1_mdata};
            last_r         <= 1'b1;
        end else begin
            rd_req_en_r    <= 1'b0;
        end
    end

    // Response steering: payload goes to both channels, only the valid differs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp_mdata_r  <= {(MDATA-1){1'b0}};
            rsp_data_r   <= {CACHE_WIDTH{1'b0}};
        end else begin
            rsp0_valid_r <= dec0_s;
            rsp1_valid_r <= dec1_s;
            rsp_mdata_r  <= rd_rsp_mdata[MDATA-2:0];
            rsp_data_r   <= rd_rsp_data;
        end
    end

    // Outstanding-read credit counters and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt0_r <= CNT_ZERO;
            cnt1_r <= CNT_ZERO;
            err_r  <= 1'b0;
        end else begin
            cnt0_r <= next_cnt(cnt0_r, grant0_s, dec0_s);
            cnt1_r <= next_cnt(cnt1_r, grant1_s, dec1_s);
            err_r  <= err_r | (dec0_s & (cnt0_r == CNT_ZERO))
                            | (dec1_s & (cnt1_r == CNT_ZERO));
        end
    end

    assign req0_grant      = grant0_s;
    assign req1_grant      = grant1_s;
    assign req0_almostfull = rd_req_almostfull | (cnt0_r >= CNT_HI);
    assign req1_almostfull = rd_req_almostfull | (cnt1_r >= CNT_HI);
    assign rd_req_en       = rd_req_en_r;
    assign rd_req_addr     = rd_req_addr_r;
    assign rd_req_mdata    = rd_req_mdata_r;
    assign rsp0_valid      = rsp0_valid_r;
    assign rsp1_valid      = rsp1_valid_r;
    assign rsp0_mdata      = rsp_mdata_r;
    assign rsp1_mdata      = rsp_mdata_r;
    assign rsp0_data       = rsp_data_r;
    assign rsp1_data       = rsp_data_r;
    assign idle            = (cnt0_r == CNT_ZERO) & (cnt1_r == CNT_ZERO) & ~rd_req_en_r;
    assign err             = err_r;

endmodule

// File: tb/tb_rd_req_arbiter.sv
// Scoreboard bench for rd_req_arbiter: a driver predicts grants and queues expected
// shared requests / routed responses; a monitor pops and compares when the DUT presents them.
module tb_rd_req_arbiter;

    localparam int AL   = 20;
    localparam int MD   = 14;
    localparam int DW   = 64;
    localparam int MAXO = 4;

    typedef struct packed {
        logic [AL-1:0] addr;
        logic [MD-1:0] mdata;
    } req_t;

    typedef struct packed {
        logic [MD-2:0] mdata;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AL-1:0] req0_addr = '0, req1_addr = '0;
    logic [MD-2:0] req0_mdata = '0, req1_mdata = '0;
    logic          req0_en = 1'b0, req1_en = 1'b0;
    logic          req0_grant, req1_grant, req0_almostfull, req1_almostfull;
    logic [AL-1:0] rd_req_addr;
    logic [MD-1:0] rd_req_mdata;
    logic          rd_req_en;
    logic          rd_req_almostfull = 1'b0;
    logic          rd_rsp_valid = 1'b0;
    logic [MD-1:0] rd_rsp_mdata = '0;
    logic [DW-1:0] rd_rsp_data = '0;
    logic          rsp0_valid, rsp1_valid;
    logic [MD-2:0] rsp0_mdata, rsp1_mdata;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic          idle, err;

    int total = 0;
    int bad = 0;

    req_t req_q[$];
    rsp_t rsp0_q[$];
    rsp_t rsp1_q[$];

    // Reference state: outstanding reads per requester, last winner, sticky error.
    int m_cnt[2] = '{0, 0};
    int m_last = 1;
    bit m_err = 1'b0;
    bit m_pend = 1'b0;
    bit prev_rst = 1'b0;

    rd_req_arbiter #(
        .ADDR_LMT(AL), .MDATA(MD), .CACHE_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_addr(req0_addr), .req0_mdata(req0_mdata), .req0_en(req0_en),
        .req0_grant(req0_grant), .req0_almostfull(req0_almostfull),
        .req1_addr(req1_addr), .req1_mdata(req1_mdata), .req1_en(req1_en),
        .req1_grant(req1_grant), .req1_almostfull(req1_almostfull),
        .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
        .rd_req_almostfull(rd_req_almostfull),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
        .rsp0_valid(rsp0_valid), .rsp0_mdata(rsp0_mdata), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_mdata(rsp1_mdata), .rsp1_data(rsp1_data),
        .idle(idle), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare combinational outputs, advance the model.
    task automatic step(input bit rst, input bit e0, input bit e1, input bit af,
                        input bit rv, input bit rid, input logic [MD-2:0] rtag);
        logic [63:0] r;
        int g;
        bit el0, el1;
        @(posedge clk);
        #2;
        reset_n = ~rst;
        req0_en = e0;
        req1_en = e1;
        r = {$urandom, $urandom};
        req0_addr  = r[AL-1:0];
        req0_mdata = r[AL+MD-2:AL];
        r = {$urandom, $urandom};
        req1_addr  = r[AL-1:0];
        req1_mdata = r[AL+MD-2:AL];
        rd_req_almostfull = af;
        rd_rsp_valid = rv & ~rst;
        rd_rsp_mdata = {rid, rtag};
        rd_rsp_data  = {$urandom, $urandom};
        #1;
        if (prev_rst) begin
            check("reset_addr", 64'(rd_req_addr), 64'd0);
            check("reset_mdata", 64'(rd_req_mdata), 64'd0);
            check("reset_rsp0_data", 64'(rsp0_data), 64'd0);
            check("reset_rsp1_mdata", 64'(rsp1_mdata), 64'd0);
        end
        el0 = !rst && e0 && !af && (m_cnt[0] != MAXO);
        el1 = !rst && e1 && !af && (m_cnt[1] != MAXO);
        g = -1;
        if (el0 && el1) g = (m_last == 0) ? 1 : 0;
        else if (el0) g = 0;
        else if (el1) g = 1;
        check("grant0", 64'(req0_grant), 64'(g == 0));
        check("grant1", 64'(req1_grant), 64'(g == 1));
        check("almostfull0", 64'(req0_almostfull), 64'(af || (m_cnt[0] >= MAXO - 1)));
        check("almostfull1", 64'(req1_almostfull), 64'(af || (m_cnt[1] >= MAXO - 1)));
        check("idle", 64'(idle), 64'(m_cnt[0] == 0 && m_cnt[1] == 0 && !m_pend));
        check("err", 64'(err), 64'(m_err));
        if (rst) begin
            m_cnt[0] = 0;
            m_cnt[1] = 0;
            m_last = 1;
            m_err = 1'b0;
            m_pend = 1'b0;
        end else begin
            if (g == 0) req_q.push_back('{addr: req0_addr, mdata: {1'b0, req0_mdata}});
            if (g == 1) req_q.push_back('{addr: req1_addr, mdata: {1'b1, req1_mdata}});
            if (g >= 0) m_last = g;
            m_pend = (g >= 0);
            if (rv) begin
                if (rid) rsp1_q.push_back('{mdata: rtag, data: rd_rsp_data});
                else     rsp0_q.push_back('{mdata: rtag, data: rd_rsp_data});
            end
            for (int n = 0; n < 2; n++) begin
                bit dec;
                dec = rv && (int'(rid) == n);
                if (dec && m_cnt[n] == 0) m_err = 1'b1;
                if (g == n) m_cnt[n] = m_cnt[n] + 1;
                if (dec && m_cnt[n] > 0) m_cnt[n] = m_cnt[n] - 1;
            end
        end
        prev_rst = rst;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a request or response.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rd_req_en === 1'b1) begin
                if (req_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_req_unexpected: actual=1 expected=0 at %0t", $time);
                end else begin
                    req_t e;
                    e = req_q.pop_front();
                    check("rd_req_addr", 64'(rd_req_addr), 64'(e.addr));
                    check("rd_req_mdata", 64'(rd_req_mdata), 64'(e.mdata));
                end
            end
            if (rsp0_valid === 1'b1) begin
                if (rsp0_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rsp0_unexpected: actual=1 expected=0 at %0t", $time);
                end else begin
                    rsp_t e;
                    e = rsp0_q.pop_front();
                    check("rsp0_mdata", 64'(rsp0_mdata), 64'(e.mdata));
                    check("rsp0_data", rsp0_data, e.data);
                end
            end
            if (rsp1_valid === 1'b1) begin
                if (rsp1_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rsp1_unexpected: actual=1 expected=0 at %0t", $time);
                end else begin
                    rsp_t e;
                    e = rsp1_q.pop_front();
                    check("rsp1_mdata", 64'(rsp1_mdata), 64'(e.mdata));
                    check("rsp1_data", rsp1_data, e.data);
                end
            end
        end
    end

    // Directed scenarios followed by a randomized stretch.
    initial begin
        int rid;
        logic [31:0] r;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'(i), 13'(i));
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 13'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'(i), 13'h0A0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 13'h011);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h022);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 13'h033);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 13'h005);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h1FF);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 13'h006);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h0EE);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0);
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            rid = int'(r[0]);
            step(1'b0, r[3:1] != 3'd0, r[6:4] != 3'd0, r[9:7] == 3'd0,
                 (r[11:10] != 2'd0) && (m_cnt[rid] > 0), r[0], r[24:12]);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0);
        check("req_q_drained", 64'(req_q.size()), 64'd0);
        check("rsp0_q_drained", 64'(rsp0_q.size()), 64'd0);
        check("rsp1_q_drained", 64'(rsp1_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
